// File: rtl/ace_snoop_datapath.sv
// Snoop engine behind ace_controller: lookup, CR_RESP/next-state resolution, CD line sourcing; stats under `ACE_SNOOP_STATS_EN.
// Outcome pulse 3 cycles after ac_enable; CD beats advance only on CD_VALID&&CD_READY; ac_enable ignored while busy.
module ace_snoop_datapath #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int INDEX_W    = 6,
   parameter int OFFSET_W   = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ac_enable,
   input  logic [ADDR_W-1:0]                  AC_ADDR,
   input  logic [3:0]                         AC_SNOOP,
   output logic                               lookup_req,
   output logic [INDEX_W-1:0]                 lookup_index,
   output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] lookup_tag,
   input  logic                               lookup_hit,
   input  logic [2:0]                         lookup_state,
   input  logic [LINE_WORDS*DATA_W-1:0]       lookup_data,
   output logic                               state_wr_en,
   output logic [2:0]                         state_wr_val,
   output logic                               snoop_miss,
   output logic                               response,
   output logic                               response_data,
   output logic [4:0]                         CR_RESP,
   input  logic                               CD_VALID,
   input  logic                               CD_READY,
   output logic [DATA_W-1:0]                  CD_DATA,
   output logic                               CD_LAST,
   output logic                               busy,
   output logic [15:0]                        hit_count,
   output logic [15:0]                        miss_count
);
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   localparam logic [2:0] ST_I  = 3'd0;
   localparam logic [2:0] ST_UC = 3'd1;
   localparam logic [2:0] ST_UD = 3'd2;
   localparam logic [2:0] ST_SC = 3'd3;
   localparam logic [2:0] ST_SD = 3'd4;

   localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
   localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
   localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
   localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
   localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

   typedef enum logic [1:0] {IDLE, LOOKUP, RESOLVE, DATA} fsm_t;

   fsm_t                       fsm;
   logic [ADDR_W-OFFSET_W-1:0] line_addr_q;
   logic [3:0]                 snoop_q;
   logic [DATA_W-1:0]          line_q [LINE_WORDS];
   logic [BEAT_W-1:0]          beat;

   logic       valid_hit, dirty, was_unique, known;
   logic       dt, shared, pass_dirty, wr_req, hit_ok;
   logic [2:0] next_line;
   logic [4:0] resp_c;

   // Byte offset within the line never reaches the cache array.
   logic unused_offset;
   assign unused_offset = ^AC_ADDR[OFFSET_W-1:0];

   assign lookup_index = line_addr_q[INDEX_W-1:0];
   assign lookup_tag   = line_addr_q[ADDR_W-OFFSET_W-1:INDEX_W];
   assign busy         = (fsm != IDLE);
   assign CD_DATA      = (fsm == DATA) ? line_q[beat] : '0;
   assign CD_LAST      = (fsm == DATA) && (beat == LAST_BEAT);

   always_comb begin
      valid_hit  = lookup_hit && (lookup_state != ST_I);
      dirty      = (lookup_state == ST_UD) || (lookup_state == ST_SD);
      was_unique = (lookup_state == ST_UC) || (lookup_state == ST_UD);
      known      = 1'b0;
      dt         = 1'b0;
      shared     = 1'b0;
      pass_dirty = 1'b0;
      wr_req     = 1'b0;
      next_line  = ST_I;
      case (snoop_q)
         SNP_READ_ONCE:     begin known = 1'b1; dt = 1'b1; shared = 1'b1; end
         SNP_READ_SHARED:   begin known = 1'b1; dt = 1'b1; shared = 1'b1; pass_dirty = dirty;
                                  wr_req = 1'b1; next_line = ST_SC; end
         SNP_READ_UNIQUE:   begin known = 1'b1; dt = 1'b1; pass_dirty = dirty; wr_req = 1'b1; end
         SNP_CLEAN_INVALID: begin known = 1'b1; dt = dirty; pass_dirty = dirty; wr_req = 1'b1; end
         SNP_MAKE_INVALID:  begin known = 1'b1; wr_req = 1'b1; end
         default: ;
      endcase
      hit_ok = valid_hit && known;
      resp_c = hit_ok ? {was_unique, shared, pass_dirty, 1'b0, dt} : 5'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm           <= IDLE;
         line_addr_q   <= '0;
         snoop_q       <= '0;
         beat          <= '0;
         lookup_req    <= 1'b0;
         state_wr_en   <= 1'b0;
         state_wr_val  <= '0;
         snoop_miss    <= 1'b0;
         response      <= 1'b0;
         response_data <= 1'b0;
         CR_RESP       <= '0;
         for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
      end else begin
         lookup_req    <= 1'b0;
         state_wr_en   <= 1'b0;
         snoop_miss    <= 1'b0;
         response      <= 1'b0;
         response_data <= 1'b0;
         case (fsm)
            IDLE: if (ac_enable) begin
               line_addr_q <= AC_ADDR[ADDR_W-1:OFFSET_W];
               snoop_q     <= AC_SNOOP;
               lookup_req  <= 1'b1;
               fsm         <= LOOKUP;
            end
            LOOKUP: fsm <= RESOLVE;
            RESOLVE: begin
               CR_RESP <= resp_c;
               beat    <= '0;
               for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= lookup_data[i*DATA_W +: DATA_W];
               if (hit_ok) begin
                  state_wr_en   <= wr_req;
                  state_wr_val  <= next_line;
                  response_data <= dt;
                  response      <= !dt;
               end else begin
                  snoop_miss <= 1'b1;
               end
               fsm <= (hit_ok && dt) ? DATA : IDLE;
            end
            DATA: if (CD_VALID && CD_READY) begin
               if (beat == LAST_BEAT) begin
                  beat <= '0;
                  fsm  <= IDLE;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

`ifdef ACE_SNOOP_STATS_EN
   logic [15:0] hit_q, miss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (fsm == RESOLVE) begin
         if (valid_hit) begin
            if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
         end else if (miss_q != 16'hFFFF) begin
            miss_q <= miss_q + 16'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: doc/ace_snoop_datapath.md
# ace_snoop_datapath

Datapath-side snoop engine that sits directly behind `ace_controller` on the AC/CR/CD path. When the controller pulses `ac_enable`, this block captures the snoop address and type and performs a tag/state lookup in the cache array. It then computes `CR_RESP` and the next line state, tells the controller the outcome through exactly one of `snoop_miss`, `response` or `response_data`, and sources the line as `CD_DATA` beats when data transfer is required.

## Interface
- `ADDR_W`, 32: snoop address width.
- `DATA_W`, 32: CD data beat width.
- `LINE_WORDS`, 4: beats per cache line; must be a power of 2, ≥2.
- `INDEX_W`, 6: set index bits.
- `OFFSET_W`, 4: byte-offset bits, equal to log2(LINE_WORDS*DATA_W/8). Tag = `ADDR_W-INDEX_W-OFFSET_W` bits.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `ac_enable` in 1: 1-cycle pulse from controller; AC handshake taken.
- `AC_ADDR` in ADDR_W: snoop address, valid with `ac_enable`.
- `AC_SNOOP` in 4: snoop type, valid with `ac_enable`.
- `lookup_req` out 1: 1-cycle lookup strobe.
- `lookup_index` out INDEX_W: `addr[OFFSET_W+:INDEX_W]`.
- `lookup_tag` out tag width: upper address bits.
- `lookup_hit` in 1: lookup result, valid the cycle after `lookup_req`.
- `lookup_state` in 3: line state: 0 I, 1 UC, 2 UD, 3 SC, 4 SD.
- `lookup_data` in LINE_WORDS*DATA_W: line data, word 0 in the LSBs.
- `state_wr_en` out 1: 1-cycle state update strobe.
- `state_wr_val` out 3: new line state, valid with `state_wr_en`.
- `snoop_miss`, `response`, `response_data` out 1 each: 1-cycle outcome pulses to the controller; mutually exclusive.
- `CR_RESP` out 5: bit0 DataTransfer, bit1 Error (always 0), bit2 PassDirty, bit3 IsShared, bit4 WasUnique.
- `CD_VALID`, `CD_READY` in 1 each: observed CD handshake; the controller owns `CD_VALID`.
- `CD_DATA` out DATA_W: current beat.
- `CD_LAST` out 1: high on the final beat.
- `busy` out 1: high in every state other than IDLE.
- `hit_count`, `miss_count` out 16: statistics (see Configuration).

## Operation
- FSM states: IDLE, LOOKUP, RESOLVE, DATA.
- IDLE: on `ac_enable`, capture `AC_ADDR`/`AC_SNOOP` and go to LOOKUP.
- LOOKUP: `lookup_req`=1; go to RESOLVE.
- RESOLVE: sample `lookup_hit`/`lookup_state`/`lookup_data`; register `CR_RESP`, pulse and state update; go to DATA if DataTransfer=1, otherwise IDLE.
- Hit with `lookup_state`=0 counts as a miss. Dirty = UD or SD. WasUnique = UC or UD.
- ReadOnce `0000`: DT=1, IsShared=1, WasUnique, PassDirty=0; state unchanged, so no `state_wr_en`.
- ReadShared `0001`: DT=1, IsShared=1, WasUnique, PassDirty=dirty; new state SC.
- ReadUnique `0111`: DT=1, WasUnique, PassDirty=dirty; new state I.
- CleanInvalid `1001`: DT=dirty, PassDirty=dirty, WasUnique; new state I.
- MakeInvalid `1101`: `CR_RESP`=0 except WasUnique; new state I.
- Miss or any other code: `CR_RESP`=0, `snoop_miss` pulse, no state write.
- Hit outcome pulse: `response_data` if DT=1, else `response`.
- DATA: `CD_DATA`=word[beat]. `beat` is a log2(LINE_WORDS)-bit counter from 0 that advances on `CD_VALID&&CD_READY`. `CD_LAST` = (beat==LINE_WORDS-1). Acceptance of the last beat returns to IDLE and clears `beat`.
- `ac_enable` while `busy`=1 is ignored.

## Timing
- `ac_enable` sampled at edge N. `lookup_req` high in cycle N+1. Result sampled at the end of N+2. Outcome pulse, `state_wr_en` and `CR_RESP` are valid in cycle N+3.
- `CR_RESP` holds its value until the next RESOLVE.
- First beat is presented in N+3. Minimum DATA duration is LINE_WORDS cycles.
- A no-data snoop returns to IDLE at N+3, so the next `ac_enable` can be accepted at N+3.
- Reset values: all outputs 0, FSM IDLE, `beat`=0, captured registers 0.
- Reset asserted mid-operation aborts immediately: no pulse, no state write, and `CD_LAST` drops.

## Configuration
- `ACE_SNOOP_STATS_EN` defined:
  - `hit_count` increments in RESOLVE on a valid hit; `miss_count` increments on a miss.
  - Both saturate at 16'hFFFF and clear only on reset.
- `ACE_SNOOP_STATS_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- ReadShared `0001`, hit, state UD, LINE_WORDS=4, `CD_READY`=1 → `response_data` at N+3, `CR_RESP`=5'b11101, `state_wr_val`=SC, four beats, `CD_LAST` on the 4th.
- MakeInvalid `1101`, hit, state SC → `response`, `CR_RESP`=0, `state_wr_val`=I, no CD beats, `busy` low at N+3.
- ReadUnique `0111`, `lookup_hit`=0 → `snoop_miss`, `CR_RESP`=0, no `state_wr_en`, `miss_count`=1 with the macro defined.
- CleanInvalid `1001`, hit, state UC → `response`, `CR_RESP`=5'b10000, `state_wr_val`=I.
- ReadOnce, state SD, `CD_READY` stalled 3 cycles on beat 2 → `CD_DATA` holds word 2 during the stall, no state write, `CR_RESP`=5'b01001.
- Second `ac_enable` during DATA is ignored; `rst` pulsed at beat 1 → all outputs 0 next cycle, FSM IDLE.
